md_sched: RTL
=============

MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, the number of cycles Busy stays high after a multiply start.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, the number of cycles Busy stays high after a divide start.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 SHALL have port Start, input, 1, the EX-stage instruction is a HI/LO operation this cycle.
REQ-006 SHALL have port Op, input, 3, operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-007 SHALL have ports A and B, input, 32 each, EX-stage forwarded rs and rt operands.
REQ-008 SHALL have port ID_UsesMD, input, 1, the ID-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
REQ-009 SHALL have port Busy, output, 1, a multiply or divide is in progress.
REQ-010 SHALL have port Stall, output, 1, hold IF/ID and zero the ID/EX register this cycle.
REQ-011 SHALL have ports HI and LO, output, 32 each, the architectural HI/LO registers.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV with a down-counter and operand/result holding registers.
REQ-013 SHALL, in IDLE with Start=1 and Op in 0-1, capture A, B and signedness, load counter with MUL_CYCLES, enter MUL and raise Busy at that edge.
REQ-014 SHALL, in IDLE with Start=1 and Op in 2-3, capture operands, load counter with DIV_CYCLES, enter DIV and raise Busy at that edge.
REQ-015 SHALL decrement the counter each edge in MUL/DIV; on the edge it reaches zero, write HI/LO, drop Busy and return to IDLE, so Busy is high exactly MUL_CYCLES or DIV_CYCLES cycles.
REQ-016 SHALL compute MULT/MULTU as the 64-bit signed/unsigned product, {HI,LO} = A*B.
REQ-017 SHALL compute DIV/DIVU with LO = quotient truncated toward zero, HI = remainder carrying the dividend's sign (DIV) or unsigned (DIVU).
REQ-018 SHALL, on divide with B=0, still run the full DIV_CYCLES with Busy high but leave HI and LO unchanged at completion.
REQ-019 SHALL, in IDLE with Start=1, write HI=A (Op 4) or LO=A (Op 5) at that edge with no Busy cycle.
REQ-020 SHALL ignore Start when Busy=1 or Op is 6-7; no state, counter or HI/LO change.
REQ-021 SHALL hold HI and LO unchanged while Busy=1 until the completion edge.
REQ-022 SHALL drive Stall = ID_UsesMD AND (Busy OR (Start AND Op in 0-3)), purely combinational, zero latency.
REQ-023 SHALL keep results of the completing operation visible on HI/LO in the cycle immediately after the completion edge.

Reset
REQ-024 SHALL, on reset=0 at any time including mid-operation, immediately force state IDLE, counter 0, Busy 0, HI 0, LO 0, independent of clk.
REQ-025 SHALL treat Stall as 0 while reset=0 only through Busy=0; Start/ID_UsesMD remain combinationally honoured.
REQ-026 SHALL accept a new Start on the first rising edge after reset returns to 1.

Configuration
REQ-027 SHALL, when macro MD_FAST_MUL_EN is defined, complete MULT/MULTU at the Start edge (HI/LO written, no MUL state, Busy stays 0, Stall excludes Op 0-1).
REQ-028 SHALL, when MD_FAST_MUL_EN is undefined, behave per REQ-013/015 with MUL_CYCLES latency; divide behaviour is identical in both builds.

Verification
REQ-029 SHALL cover: MULT A=0xFFFFFFFE, B=3 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 SHALL cover: DIV A=-7 (0xFFFFFFF9), B=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=2 -> LO=3, HI=1.
REQ-031 SHALL cover: DIVU A=5, B=0 with prior HI=0x11, LO=0x22 -> Busy 10 cycles, HI=0x11, LO=0x22 after.
REQ-032 SHALL cover: MULTU started, ID_UsesMD=1 throughout -> Stall=1 on Start cycle and all 5 Busy cycles, 0 the cycle after; second Start during Busy ignored.
REQ-033 SHALL cover: DIV started, reset=0 pulsed at cycle 4 between edges -> Busy, HI, LO read 0 before the next clk edge; MTHI A=0x1234 after release -> HI=0x1234 at that edge.
REQ-034 SHALL cover: MD_FAST_MUL_EN defined, MULT A=2, B=3 -> LO=6, HI=0 at Start edge, Busy never asserted.

Source files
------------

// File: rtl/md_sched.sv
// md_sched: HI/LO multiply-divide scheduler for the EX stage.
// Runs multi-cycle MULT/MULTU/DIV/DIVU, writes MTHI/MTLO immediately,
// and raises a combinational Stall for ID-stage HI/LO users.
// Optional feature macro: MD_FAST_MUL_EN (single-cycle multiply at the Start edge).
module md_sched #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        ID_UsesMD,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic               sgn_q;

    logic [31:0]        mul_a;
    logic [31:0]        mul_b;
    logic               mul_sgn;
    logic [63:0]        mul_prod;
    logic [31:0]        b_div;
    logic [31:0]        div_q;
    logic [31:0]        div_r;
    logic               md_op_c;

    // Multiply operand source: live inputs in the fast build, held operands otherwise
`ifdef MD_FAST_MUL_EN
    assign mul_a   = A;
    assign mul_b   = B;
    assign mul_sgn = ~Op[0];
    assign md_op_c = (Op[2:1] == 2'b01);
`else
    assign mul_a   = a_q;
    assign mul_b   = b_q;
    assign mul_sgn = sgn_q;
    assign md_op_c = ~Op[2];
`endif

    // Result datapath: 64-bit product plus truncating quotient/remainder of held operands
    always_comb begin
        mul_prod = {{32{mul_sgn & mul_a[31]}}, mul_a} * {{32{mul_sgn & mul_b[31]}}, mul_b};
        b_div    = (b_q == 32'd0) ? 32'd1 : b_q;
        if (sgn_q) begin
            div_q = 32'($signed(a_q) / $signed(b_div));
            div_r = 32'($signed(a_q) % $signed(b_div));
        end else begin
            div_q = a_q / b_div;
            div_r = a_q % b_div;
        end
    end

    // ID-stage hazard: hold the pipe while HI/LO is pending or about to be
    assign Stall = ID_UsesMD & (Busy | (Start & md_op_c));

    // Scheduler FSM, operand capture and HI/LO update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (Op)
                            3'd0, 3'd1: begin
`ifdef MD_FAST_MUL_EN
                                HI <= mul_prod[63:32];
                                LO <= mul_prod[31:0];
`else
                                a_q   <= A;
                                b_q   <= B;
                                sgn_q <= ~Op[0];
                                cnt   <= CNT_W'(MUL_CYCLES);
                                state <= MUL;
                                Busy  <= 1'b1;
`endif
                            end
                            3'd2, 3'd3: begin
                                a_q   <= A;
                                b_q   <= B;
                                sgn_q <= ~Op[0];
                                cnt   <= CNT_W'(DIV_CYCLES);
                                state <= DIV;
                                Busy  <= 1'b1;
                            end
                            3'd4:    HI <= A;
                            3'd5:    LO <= A;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1)) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        if (state == MUL) begin
                            HI <= mul_prod[63:32];
                            LO <= mul_prod[31:0];
                        end else if (b_q != 32'd0) begin
                            HI <= div_r;
                            LO <= div_q;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
